// File: rtl/alu_iterative_unit.sv
// Multi-cycle ALU for MUL, ROTR, CLO and CLZ: accepts one request, iterates one
// step per clock, and holds the registered response until it is consumed.
module alu_iterative_unit #(
    parameter bit MUL_SIGNED = 1'b1
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [3:0]  ReqOp,
    input  logic [31:0] ReqA,
    input  logic [31:0] ReqB,
    output logic        RspValid,
    input  logic        RspReady,
    output logic [31:0] RspResult,
    output logic [31:0] RspHi,
    output logic        RspZero,
    output logic        RspErr
);

    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_ROTR = 4'b1010;
    localparam logic [3:0] OP_CLO  = 4'b1011;
    localparam logic [3:0] OP_CLZ  = 4'b1100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [63:0] acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;
    logic [31:0] res_q, res_d;
    logic [31:0] hi_q, hi_d;
    logic        zero_q, zero_d;
    logic        err_q, err_d;

    logic        finish;
    logic [31:0] fin_lo, fin_hi;
    logic        fin_err;
    logic [32:0] sum;
    logic [63:0] acc_step, prod;
    logic [31:0] rot;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        res_d    = res_q;
        hi_d     = hi_q;
        zero_d   = zero_q;
        err_d    = err_q;
        finish   = 1'b0;
        fin_lo   = '0;
        fin_hi   = '0;
        fin_err  = 1'b0;
        sum      = '0;
        acc_step = '0;
        prod     = '0;
        rot      = '0;

        case (state_q)
            IDLE: begin
                if (ReqValid && ready_q) begin
                    state_d = BUSY;
                    op_d    = ReqOp;
                    a_d     = ReqA;
                    acc_d   = '0;
                    cnt_d   = '0;
                    neg_d   = 1'b0;
                    case (ReqOp)
                        OP_MUL: begin
                            // Multiplier magnitude sits in the accumulator's low half and shifts out as the product shifts in.
                            a_d   = (MUL_SIGNED && ReqA[31]) ? -ReqA : ReqA;
                            acc_d = {32'd0, (MUL_SIGNED && ReqB[31]) ? -ReqB : ReqB};
                            neg_d = MUL_SIGNED && (ReqA[31] ^ ReqB[31]);
                        end
                        OP_ROTR: cnt_d = {1'b0, ReqB[4:0]};
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                case (op_q)
                    OP_MUL: begin
                        sum      = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? a_q : 32'd0)};
                        acc_step = {sum, acc_q[31:1]};
                        acc_d    = acc_step;
                        cnt_d    = cnt_q + 6'd1;
                        prod     = neg_q ? -acc_step : acc_step;
                        if (cnt_q == 6'd31) begin
                            finish = 1'b1;
                            fin_lo = prod[31:0];
                            fin_hi = prod[63:32];
                        end
                    end
                    OP_ROTR: begin
                        // A zero amount still spends one cycle but leaves the operand untouched.
                        rot = (cnt_q != '0) ? {a_q[0], a_q[31:1]} : a_q;
                        a_d = rot;
                        if (cnt_q != '0) cnt_d = cnt_q - 6'd1;
                        if (cnt_q <= 6'd1) begin
                            finish = 1'b1;
                            fin_lo = rot;
                        end
                    end
                    OP_CLO, OP_CLZ: begin
                        if (a_q[31] == (op_q == OP_CLO)) begin
                            a_d   = {a_q[30:0], 1'b0};
                            cnt_d = cnt_q + 6'd1;
                            if (cnt_q == 6'd31) begin
                                finish = 1'b1;
                                fin_lo = 32'd32;
                            end
                        end else begin
                            finish = 1'b1;
                            fin_lo = {26'd0, cnt_q};
                        end
                    end
                    default: begin
                        finish  = 1'b1;
                        fin_err = 1'b1;
                    end
                endcase
                if (finish) begin
                    state_d = DONE;
                    res_d   = fin_lo;
                    hi_d    = fin_hi;
                    err_d   = fin_err;
                    zero_d  = (fin_lo == '0);
                end
            end
            DONE: begin
                if (RspReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Registered so that ReqReady stays low throughout reset.
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            res_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            op_q    <= op_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

    assign ReqReady  = ready_q;
    assign RspValid  = (state_q == DONE);
    assign RspResult = res_q;
    assign RspHi     = hi_q;
    assign RspZero   = zero_q;
    assign RspErr    = err_q;

endmodule

// File: tb/tb_alu_iterative_unit.sv
// Bench for alu_iterative_unit: directed and random operations compared every
// cycle against an arithmetic reference model of each opcode.
module tb_alu_iterative_unit;

    localparam bit MUL_SIGNED = 1'b1;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_ROTR = 4'b1010;
    localparam logic [3:0] OP_CLO  = 4'b1011;
    localparam logic [3:0] OP_CLZ  = 4'b1100;

    logic        Clk;
    logic        Rst;
    logic        ReqValid;
    logic        ReqReady;
    logic [3:0]  ReqOp;
    logic [31:0] ReqA;
    logic [31:0] ReqB;
    logic        RspValid;
    logic        RspReady;
    logic [31:0] RspResult;
    logic [31:0] RspHi;
    logic        RspZero;
    logic        RspErr;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_lo, m_hi;
    logic        m_err;
    int          m_lat;
    bit          pending = 1'b0;
    bit          seen    = 1'b0;
    int          since   = 0;

    alu_iterative_unit #(.MUL_SIGNED(MUL_SIGNED)) dut (
        .Clk(Clk), .Rst(Rst),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp), .ReqA(ReqA), .ReqB(ReqB),
        .RspValid(RspValid), .RspReady(RspReady), .RspResult(RspResult), .RspHi(RspHi),
        .RspZero(RspZero), .RspErr(RspErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference behaviour straight from the opcode definitions.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] lo, output logic [31:0] hi,
                                  output logic err, output int lat);
        logic [63:0] p;
        int n, c;
        logic tgt;
        lo = '0; hi = '0; err = 1'b0; lat = 1;
        case (op)
            OP_MUL: begin
                if (MUL_SIGNED) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                else            p = {32'd0, a} * {32'd0, b};
                lo  = p[31:0];
                hi  = p[63:32];
                lat = 32;
            end
            OP_ROTR: begin
                n = int'(b[4:0]);
                if (n == 0) lo = a;
                else begin
                    lo  = (a >> n) | (a << (32 - n));
                    lat = n;
                end
            end
            OP_CLO, OP_CLZ: begin
                tgt = (op == OP_CLO);
                c = 0;
                for (int i = 31; i >= 0; i--) begin
                    if (a[i] != tgt) break;
                    c++;
                end
                lo  = 32'(c);
                lat = (c + 1 > 32) ? 32 : c + 1;
            end
            default: err = 1'b1;
        endcase
    endfunction

    // Monitor: learns each accepted request and checks every response cycle.
    always @(negedge Clk) begin
        if (!Rst) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                since++;
                if (RspValid) begin
                    if (!seen) begin
                        seen = 1'b1;
                        chk("latency", 64'(since), 64'(m_lat));
                    end
                    chk("RspResult", 64'(RspResult), 64'(m_lo));
                    chk("RspHi", 64'(RspHi), 64'(m_hi));
                    chk("RspZero", 64'(RspZero), 64'(m_lo == 32'd0));
                    chk("RspErr", 64'(RspErr), 64'(m_err));
                    chk("ReqReady in DONE", 64'(ReqReady), 64'd0);
                    if (RspReady) pending = 1'b0;
                end else if (since > 64) begin
                    chk("response timeout", 64'd0, 64'd1);
                    pending = 1'b0;
                end
            end else begin
                chk("idle RspValid", 64'(RspValid), 64'd0);
            end
            if (ReqValid && ReqReady) begin
                model(ReqOp, ReqA, ReqB, m_lo, m_hi, m_err, m_lat);
                pending = 1'b1;
                seen    = 1'b0;
                since   = -1;
            end
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, " ReqReady"}, 64'(ReqReady), 64'd0);
        chk({tag, " RspValid"}, 64'(RspValid), 64'd0);
        chk({tag, " RspResult"}, 64'(RspResult), 64'd0);
        chk({tag, " RspHi"}, 64'(RspHi), 64'd0);
        chk({tag, " RspZero"}, 64'(RspZero), 64'd1);
        chk({tag, " RspErr"}, 64'(RspErr), 64'd0);
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bit ok = 1'b0;
        ReqOp = op; ReqA = a; ReqB = b; ReqValid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (ReqReady) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept timeout", 64'd0, 64'd1);
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        ReqA = $urandom();
        ReqB = $urandom();
    endtask

    task automatic wait_rsp(input int hold);
        bit ok = 1'b0;
        RspReady = (hold == 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (RspValid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("RspValid timeout", 64'd0, 64'd1);
        if (hold > 0) begin
            repeat (hold) @(posedge Clk);
            #1 RspReady = 1'b1;
        end
        @(posedge Clk); #1;
    endtask

    task automatic pin(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_lo, input logic [31:0] exp_hi, input logic exp_err, input int exp_lat);
        logic [31:0] lo, hi;
        logic err;
        int lat;
        model(op, a, b, lo, hi, err, lat);
        chk({name, " model lo"}, 64'(lo), 64'(exp_lo));
        chk({name, " model hi"}, 64'(hi), 64'(exp_hi));
        chk({name, " model err"}, 64'(err), 64'(exp_err));
        chk({name, " model lat"}, 64'(lat), 64'(exp_lat));
        issue(op, a, b);
        wait_rsp(0);
    endtask

    function automatic logic [31:0] lead_pat(input int k, input bit ones);
        logic [31:0] all1, v;
        all1 = '1;
        if (k >= 32) v = all1;
        else v = ~(all1 >> k) | ($urandom() & (all1 >> (k + 1)));
        return ones ? v : ~v;
    endfunction

    initial begin
        int r, k;
        logic [3:0]  op;
        logic [31:0] a, b;
        bit ok;

        Rst = 1'b0; ReqValid = 1'b0; ReqOp = '0; ReqA = '0; ReqB = '0; RspReady = 1'b1;
        repeat (3) @(posedge Clk); #1;
        chk_reset("reset");
        Rst = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk("ReqReady after release", 64'(ReqReady), 64'd1);
        @(posedge Clk); #1;

        pin("mul small", OP_MUL, 32'h000003E8, 32'h00000112, 32'h00042E50, 32'h00000000, 1'b0, 32);
        pin("mul neg",   OP_MUL, 32'hFFFF0000, 32'h0000000F, 32'hFFF10000, 32'hFFFFFFFF, 1'b0, 32);
        pin("mul m1m1",  OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 32);
        pin("rotr 1",    OP_ROTR, 32'h00000FED, 32'h00000001, 32'h800007F6, 32'h0, 1'b0, 1);
        pin("rotr 10",   OP_ROTR, 32'h00000FED, 32'h0000000A, 32'hFB400003, 32'h0, 1'b0, 10);
        pin("rotr 32",   OP_ROTR, 32'h00000FED, 32'h00000020, 32'h00000FED, 32'h0, 1'b0, 1);
        pin("clo 28",    OP_CLO, 32'hFFFFFFF1, 32'h0, 32'd28, 32'h0, 1'b0, 29);
        pin("clo 32",    OP_CLO, 32'hFFFFFFFF, 32'h0, 32'd32, 32'h0, 1'b0, 32);
        pin("clo 0",     OP_CLO, 32'h00000003, 32'h0, 32'd0, 32'h0, 1'b0, 1);
        pin("clz 30",    OP_CLZ, 32'h00000003, 32'h0, 32'd30, 32'h0, 1'b0, 31);
        pin("clz 4",     OP_CLZ, 32'h08000003, 32'h0, 32'd4, 32'h0, 1'b0, 5);
        pin("clz 32",    OP_CLZ, 32'h00000000, 32'h0, 32'd32, 32'h0, 1'b0, 32);
        pin("bad op",    4'b0001, 32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0, 1'b1, 1);

        // Back-pressure: response held, stray request ignored.
        RspReady = 1'b0;
        issue(OP_MUL, 32'h12345678, 32'h9ABCDEF0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (RspValid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("backpressure RspValid seen", 64'(ok), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk); #1;
            ReqValid = (i == 2);
            ReqOp = OP_CLZ;
            ReqA = 32'h0000FFFF;
            @(negedge Clk);
            chk("backpressure ReqReady", 64'(ReqReady), 64'd0);
        end
        @(posedge Clk); #1;
        ReqValid = 1'b0;
        RspReady = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk("idle after release ReqReady", 64'(ReqReady), 64'd1);
        chk("idle after release RspValid", 64'(RspValid), 64'd0);
        @(posedge Clk); #1;

        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            b = $urandom();
            k = $urandom_range(0, 32);
            if (r <= 2) begin
                op = OP_MUL;
                a = $urandom();
            end else if (r <= 4) begin
                op = OP_ROTR;
                a = $urandom();
            end else if (r <= 6) begin
                op = OP_CLO;
                a = lead_pat(k, 1'b1);
            end else if (r <= 8) begin
                op = OP_CLZ;
                a = lead_pat(k, 1'b0);
            end else begin
                op = 4'($urandom());
                a = $urandom();
            end
            issue(op, a, b);
            wait_rsp(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
        end

        // Abort a multiply mid-flight with reset.
        issue(OP_MUL, 32'h0000ABCD, 32'h00001234);
        repeat (10) @(posedge Clk);
        #1 Rst = 1'b0;
        #1 chk_reset("abort");
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk("abort ReqReady after release", 64'(ReqReady), 64'd1);
        repeat (40) @(posedge Clk);
        #1;
        pin("mul 3x5", OP_MUL, 32'd3, 32'd5, 32'h0000000F, 32'h0, 1'b0, 32);

        repeat (3) @(posedge Clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_iterative_unit.md
Name: alu_iterative_unit

Overview:
- Multi-cycle execution unit for the processor's expensive ALU operations: signed multiply, rotate-right, count-leading-ones and count-leading-zeros.
- Acts as the responder to the issue stage. It accepts one operation over a valid/ready request channel, iterates one step per clock, and returns the result over a valid/ready response channel.
- Opcode encodings match the ALUControl encodings of the combinational ALU32Bit, so the decoder routes these opcodes here unchanged.

Parameters:
- MUL_SIGNED, 1, 1 = signed two's-complement multiply; 0 = unsigned multiply.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-low reset.
- ReqValid  input  1  request valid.
- ReqReady  output  1  unit can accept a request.
- ReqOp  input  4  0010 MUL, 1010 ROTR, 1011 CLO, 1100 CLZ.
- ReqA  input  32  operand A.
- ReqB  input  32  operand B (ROTR uses B[4:0]; CLO and CLZ ignore B).
- RspValid  output  1  response valid.
- RspReady  input  1  consumer accepts the response.
- RspResult  output  32  result; low 32 bits of the product for MUL.
- RspHi  output  32  high 32 bits of the product for MUL; 0 for all other ops.
- RspZero  output  1  1 when RspResult == 0.
- RspErr  output  1  1 when the opcode is unsupported.

Behaviour:
- Reset (Rst = 0, asynchronous):
  - State goes to IDLE.
  - ReqReady = 0 while reset is asserted, and 1 in the first cycle after release.
  - RspValid = 0, RspResult = 0, RspHi = 0, RspZero = 1, RspErr = 0.
  - Internal operand, accumulator and counter registers are cleared.
- States: IDLE, BUSY, DONE.
  - ReqReady = 1 only in IDLE.
  - RspValid = 1 only in DONE.
- IDLE -> BUSY on the edge where ReqValid && ReqReady. Op and operands are captured on that edge; inputs are ignored afterwards.
- BUSY performs one iteration per cycle. After the last iteration edge the state moves to DONE and the outputs are registered.
  - RspValid is first high I cycles after the accept edge, where I is the iteration count below.
- Iteration counts and algorithms:
  - MUL:
    - I = 32.
    - Shift-add on operand magnitudes into a 64-bit accumulator.
    - When MUL_SIGNED = 1, the final product is negated if A[31] ^ B[31].
    - Result is {RspHi, RspResult} = A*B mod 2^64.
  - ROTR:
    - I = B[4:0] when B[4:0] != 0; I = 1 when B[4:0] == 0, which performs no rotation.
    - Each iteration rotates right by one bit: bit 0 moves to bit 31.
  - CLO / CLZ:
    - Bits are scanned MSB-first, one per cycle, stopping at the first bit that is not 1 (CLO) or not 0 (CLZ).
    - I = min(count + 1, 32).
    - Result is the count, 0..32.
  - Unsupported op: I = 1, RspResult = 0, RspHi = 0, RspErr = 1.
- RspZero and RspErr are registered together with RspResult and are valid whenever RspValid = 1.
- DONE holds RspValid and all Rsp* outputs stable until RspReady = 1.
  - On the edge where RspValid && RspReady, the state moves to IDLE.
  - ReqReady returns the following cycle; there is no same-cycle response-to-request pass-through.
- Back-to-back operation: the minimum issue interval is I + 2 cycles.
- Reset asserted mid-operation (BUSY or DONE): the operation is abandoned immediately and asynchronously, and no response is produced after release.
- ReqValid in BUSY or DONE is ignored (ReqReady = 0). The requester must hold its request until it sees ReqReady.

Test Plan:
- MUL: A=000003E8, B=00000112.
  - RspResult=00042E50, RspHi=00000000, RspZero=0.
  - RspValid first high exactly 32 cycles after the accept edge.
- MUL signed: A=FFFF0000, B=0000000F -> RspResult=FFF10000, RspHi=FFFFFFFF.
- MUL signed: A=FFFFFFFF, B=FFFFFFFF -> RspResult=00000001, RspHi=00000000.
- ROTR: A=00000FED, B=1 -> 800007F6 with latency 1.
- ROTR: A=00000FED, B=0000000A -> FB400003 with latency 10.
- ROTR: A=00000FED, B=00000020 (B[4:0]=0) -> 00000FED with latency 1.
- CLO:
  - A=FFFFFFF1 -> 28, latency 29.
  - A=FFFFFFFF -> 32, latency 32.
  - A=00000003 -> 0, RspZero=1, latency 1.
- CLZ:
  - A=00000003 -> 30.
  - A=08000003 -> 4.
  - A=00000000 -> 32, latency 32.
- Back-pressure and error handling:
  - Hold RspReady=0 for 5 cycles after RspValid: outputs stay stable, ReqReady stays 0, and a ReqValid pulse is not accepted. Release RspReady: IDLE is reached the next cycle.
  - ReqOp=0001 -> RspErr=1, RspResult=0, RspZero=1.
- Reset mid-operation:
  - Pull Rst low 10 cycles into a MUL: all outputs go to their reset values immediately. After release, ReqReady=1 and RspValid never pulses for the aborted op.
  - A subsequent MUL 3*5 returns 0000000F.
